// File: rtl/platformniosci_arb_pkg.sv
// Shared constants and types for the on-chip RAM arbiter.
package platformniosci_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;

  // Identifies one of the two master ports.
  typedef logic port_id_t;

endpackage

// File: rtl/platformniosci_rr_arb2.sv
// Two-way arbiter: round-robin on conflict (or fixed priority to port 0),
// with the last-granted port remembered across idle cycles.
module platformniosci_rr_arb2
  import platformniosci_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output port_id_t             grant_id
);

  port_id_t last_grant;

  // Pick the winning port this cycle; reset holds every grant off.
  always_comb begin
    grant    = '0;
    grant_id = 1'b0;
    if (reset_n) begin
      unique case (req)
        2'b01: begin
          grant    = 2'b01;
          grant_id = 1'b0;
        end
        2'b10: begin
          grant    = 2'b10;
          grant_id = 1'b1;
        end
        2'b11: begin
          if ((ROUND_ROBIN != 0) && (last_grant == 1'b0)) begin
            grant    = 2'b10;
            grant_id = 1'b1;
          end else begin
            grant    = 2'b01;
            grant_id = 1'b0;
          end
        end
        default: begin
          grant    = '0;
          grant_id = 1'b0;
        end
      endcase
    end
  end

  // Remember the most recent winner; reset to 1 so port 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/platformniosci_onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between two Avalon-MM masters: one
// command per cycle, read responses returned one cycle later to the
// port that issued them.
module platformniosci_onchip_mem_arbiter
  import platformniosci_arb_pkg::*;
#(
  parameter  int ADDR_W      = DEF_ADDR_W,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int ROUND_ROBIN = 1,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  port_id_t             grant_id;
  logic                 issue;
  logic [ADDR_W-1:0]    sel_address;
  logic [BE_W-1:0]      sel_byteenable;
  logic                 sel_write;
  logic [DATA_W-1:0]    sel_writedata;
  logic [ADDR_W-1:0]    addr_q;
  logic                 rd_pend;
  port_id_t             rd_id;

  // A simultaneous read+write is a write; the read is simply dropped.
  assign req = {m1_read | m1_write, m0_read | m0_write};

  platformniosci_rr_arb2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign m0_waitrequest = ~grant[0];
  assign m1_waitrequest = ~grant[1];
  assign issue          = |grant;

  // Select the granted master's command fields.
  always_comb begin
    sel_address    = grant_id ? m1_address    : m0_address;
    sel_byteenable = grant_id ? m1_byteenable : m0_byteenable;
    sel_write      = grant_id ? m1_write      : m0_write;
    sel_writedata  = grant_id ? m1_writedata  : m0_writedata;
  end

  assign mem_chipselect = issue;
  assign mem_write      = issue & sel_write;
  assign mem_address    = issue ? sel_address : addr_q;
  assign mem_byteenable = (issue & sel_write) ? sel_byteenable : '1;
  assign mem_writedata  = sel_writedata;
  assign mem_clken      = reset_n;

  // Hold the RAM address across idle cycles and track the in-flight read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      if (issue) begin
        addr_q <= sel_address;
      end
      rd_pend <= issue & ~sel_write;
      rd_id   <= grant_id;
    end
  end

  // Steer the RAM output to the port that issued the read.
  always_comb begin
    m0_readdatavalid = rd_pend & (rd_id == 1'b0);
    m1_readdatavalid = rd_pend & (rd_id == 1'b1);
    m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
  end

endmodule

// File: tb/tb_platformniosci_onchip_mem_arbiter.sv
// Bench for the on-chip RAM arbiter. Two instances (round-robin and fixed
// priority) see identical master traffic; each has its own RAM model and
// its own reference model of grants, memory contents and responses.
module tb_platformniosci_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] addr_i [2];
  logic [3:0]  be_i   [2];
  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [31:0] wd_i   [2];

  wire  [1:0][1:0]       wait_v;
  wire  [1:0][1:0]       rdv_v;
  wire  [1:0][1:0][31:0] rdata_v;
  wire  [1:0][12:0]      maddr;
  wire  [1:0][3:0]       mbe;
  wire  [1:0]            mcs, mwr, mclken;
  wire  [1:0][31:0]      mwd;
  logic [1:0][31:0]      mq;

  bit [31:0] ram     [2][8192];
  bit [31:0] ref_mem [2][8192];
  int        lg   [2];
  bit        pend [2];
  int        pid  [2];
  bit [31:0] pdata[2];
  int        ncmp = 0;
  int        nerr = 0;
  int        cnt  [2][2];

  always #5 clk = ~clk;

  platformniosci_onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_address(addr_i[0]), .m0_byteenable(be_i[0]), .m0_read(rd_i[0]), .m0_write(wr_i[0]),
    .m0_writedata(wd_i[0]), .m0_waitrequest(wait_v[0][0]), .m0_readdata(rdata_v[0][0]),
    .m0_readdatavalid(rdv_v[0][0]),
    .m1_address(addr_i[1]), .m1_byteenable(be_i[1]), .m1_read(rd_i[1]), .m1_write(wr_i[1]),
    .m1_writedata(wd_i[1]), .m1_waitrequest(wait_v[0][1]), .m1_readdata(rdata_v[0][1]),
    .m1_readdatavalid(rdv_v[0][1]),
    .mem_address(maddr[0]), .mem_byteenable(mbe[0]), .mem_chipselect(mcs[0]),
    .mem_write(mwr[0]), .mem_writedata(mwd[0]), .mem_clken(mclken[0]), .mem_readdata(mq[0])
  );

  platformniosci_onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_address(addr_i[0]), .m0_byteenable(be_i[0]), .m0_read(rd_i[0]), .m0_write(wr_i[0]),
    .m0_writedata(wd_i[0]), .m0_waitrequest(wait_v[1][0]), .m0_readdata(rdata_v[1][0]),
    .m0_readdatavalid(rdv_v[1][0]),
    .m1_address(addr_i[1]), .m1_byteenable(be_i[1]), .m1_read(rd_i[1]), .m1_write(wr_i[1]),
    .m1_writedata(wd_i[1]), .m1_waitrequest(wait_v[1][1]), .m1_readdata(rdata_v[1][1]),
    .m1_readdatavalid(rdv_v[1][1]),
    .mem_address(maddr[1]), .mem_byteenable(mbe[1]), .mem_chipselect(mcs[1]),
    .mem_write(mwr[1]), .mem_writedata(mwd[1]), .mem_clken(mclken[1]), .mem_readdata(mq[1])
  );

  // Single-port RAM with byte enables and one-cycle read latency, one per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mcs[k]) begin
        if (mwr[k]) begin
          for (int b = 0; b < 4; b++)
            if (mbe[k][b]) ram[k][maddr[k]][b*8 +: 8] <= mwd[k][b*8 +: 8];
        end else begin
          mq[k] <= ram[k][maddr[k]];
        end
      end
    end
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s inst%0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [12:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    rd_i[p] = r; wr_i[p] = w; addr_i[p] = a; be_i[p] = b; wd_i[p] = d;
  endtask

  task automatic idle();
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
  endtask

  // Check one cycle against the reference model, then advance past the clock edge.
  task automatic do_cycle();
    int  g;
    bit  ev, r0, r1;
    logic [12:0] a;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        ev = pend[k] && (pid[k] == p);
        chk("rdvalid", k, 32'(rdv_v[k][p]), 32'(ev));
        chk("rdata", k, rdata_v[k][p], ev ? pdata[k] : 32'h0);
      end
      chk("clken", k, 32'(mclken[k]), 32'(reset_n));
      g = -1;
      if (reset_n) begin
        r0 = rd_i[0] | wr_i[0];
        r1 = rd_i[1] | wr_i[1];
        if (r0 && r1)  g = (k == 0) ? 1 - lg[k] : 0;
        else if (r0)   g = 0;
        else if (r1)   g = 1;
      end
      for (int p = 0; p < 2; p++)
        chk("waitreq", k, 32'(wait_v[k][p]), 32'(g != p));
      pend[k] = 0;
      if (g < 0) begin
        chk("cs_idle", k, 32'(mcs[k]), 32'h0);
        chk("wr_idle", k, 32'(mwr[k]), 32'h0);
        if (!reset_n) lg[k] = 1;
      end else begin
        a = addr_i[g];
        chk("cs", k, 32'(mcs[k]), 32'h1);
        chk("addr", k, 32'(maddr[k]), 32'(a));
        chk("write", k, 32'(mwr[k]), 32'(wr_i[g]));
        if (wr_i[g]) begin
          chk("be", k, 32'(mbe[k]), 32'(be_i[g]));
          chk("wdata", k, mwd[k], wd_i[g]);
          for (int b = 0; b < 4; b++)
            if (be_i[g][b]) ref_mem[k][a][b*8 +: 8] = wd_i[g][b*8 +: 8];
        end else begin
          chk("be_rd", k, 32'(mbe[k]), 32'hF);
          pend[k]  = 1;
          pid[k]   = g;
          pdata[k] = ref_mem[k][a];
        end
        lg[k] = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin pend[k] = 0; lg[k] = 1; end
    do_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    for (int k = 0; k < 2; k++) begin lg[k] = 1; pend[k] = 0; pid[k] = 0; pdata[k] = 0; end

    // Reset state, with requests present that must not be granted.
    set_port(0, 1, 0, 13'h5, 4'hF, 32'h0);
    set_port(1, 0, 1, 13'h6, 4'hF, 32'h1);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_wait0", k, 32'(wait_v[k][0]), 32'h1);
      chk("rst_wait1", k, 32'(wait_v[k][1]), 32'h1);
      chk("rst_cs", k, 32'(mcs[k]), 32'h0);
      chk("rst_clken", k, 32'(mclken[k]), 32'h0);
    end
    do_cycle();
    do_cycle();
    idle();
    reset_n = 1'b1;

    // Write then read back through port 0.
    set_port(0, 0, 1, 13'h0010, 4'hF, 32'hDEADBEEF);
    do_cycle();
    set_port(0, 1, 0, 13'h0010, 4'hF, 32'h0);
    do_cycle();
    chk("t1_data", 0, rdata_v[0][0], 32'hDEADBEEF);
    chk("t1_m1_novalid", 0, 32'(rdv_v[0][1]), 32'h0);
    idle();
    do_cycle();

    // Simultaneous reads straight out of reset: port 0 first, then port 1.
    set_port(0, 0, 1, 13'h0001, 4'hF, 32'h11110001);
    do_cycle();
    set_port(0, 0, 1, 13'h0002, 4'hF, 32'h22220002);
    do_cycle();
    do_reset();
    set_port(0, 1, 0, 13'h0001, 4'hF, 32'h0);
    set_port(1, 1, 0, 13'h0002, 4'hF, 32'h0);
    do_cycle();
    chk("t2_first", 0, rdata_v[0][0], 32'h11110001);
    set_port(0, 0, 0, '0, '0, '0);
    do_cycle();
    chk("t2_second", 0, rdata_v[0][1], 32'h22220002);
    idle();
    do_cycle();

    // Sustained conflict for 8 cycles.
    do_reset();
    set_port(0, 1, 0, 13'h0003, 4'hF, 32'h0);
    set_port(1, 1, 0, 13'h0004, 4'hF, 32'h0);
    for (int k = 0; k < 2; k++) begin cnt[k][0] = 0; cnt[k][1] = 0; end
    for (int i = 0; i < 8; i++) begin
      do_cycle();
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++)
          cnt[k][p] += int'(rdv_v[k][p]);
    end
    chk("rr_cnt0", 0, 32'(cnt[0][0]), 32'd4);
    chk("rr_cnt1", 0, 32'(cnt[0][1]), 32'd4);
    chk("fp_cnt0", 1, 32'(cnt[1][0]), 32'd8);
    chk("fp_cnt1", 1, 32'(cnt[1][1]), 32'd0);
    set_port(0, 0, 0, '0, '0, '0);
    do_cycle();
    idle();
    do_cycle();

    // Partial-word write merges into the existing word.
    set_port(0, 0, 1, 13'h0020, 4'hF, 32'hAAAAAAAA);
    do_cycle();
    set_port(0, 0, 1, 13'h0020, 4'h3, 32'h11223344);
    do_cycle();
    set_port(0, 1, 0, 13'h0020, 4'hF, 32'h0);
    do_cycle();
    chk("be_merge", 0, rdata_v[0][0], 32'hAAAA3344);
    idle();
    do_cycle();

    // Reset asserted while a read response is pending.
    set_port(0, 1, 0, 13'h0010, 4'hF, 32'h0);
    do_cycle();
    idle();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_rdv0", k, 32'(rdv_v[k][0]), 32'h0);
      chk("mid_rdv1", k, 32'(rdv_v[k][1]), 32'h0);
      chk("mid_rdata0", k, rdata_v[k][0], 32'h0);
      chk("mid_wait0", k, 32'(wait_v[k][0]), 32'h1);
      chk("mid_wait1", k, 32'(wait_v[k][1]), 32'h1);
      chk("mid_clken", k, 32'(mclken[k]), 32'h0);
      pend[k] = 0;
      lg[k] = 1;
    end
    do_cycle();
    reset_n = 1'b1;
    do_cycle();
    do_cycle();

    // Random traffic with a small address window to exercise hazards.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        int op;
        op = $urandom_range(0, 9);
        set_port(p, (op <= 3) || (op == 7), (op >= 4) && (op <= 7),
                 13'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      end
      do_cycle();
    end
    idle();
    do_cycle();
    do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
